fm_discrim: RTL and testbench

FM_DISCRIM -- requirements
Module: fm_discrim

---
 rtl/fm_discrim.sv | 129 ++++++++++++
 tb/tb_fm_discrim.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_discrim.sv
// FM discriminator: per-sample phase difference, accumulated and decimated by DECIM.
// Define FM_DISCRIM_SQUELCH_EN to zero the contribution of samples whose magnitude is below MAG_THRESH.
module fm_discrim #(
  parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int          DECIM                  = 8,
  parameter logic [15:0] MAG_THRESH             = 16'd64
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                                  s00_axis_tlast,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                  m00_axis_tlast,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = 16 + SHIFT;

  logic signed [15:0]      angle;
  logic [15:0]             mag;
  logic                    squelch;
  logic                    accept;
  logic                    close;
  logic signed [15:0]      diff;
  logic signed [ACC_W-1:0] acc_sum;

  logic signed [15:0]      prev_angle_q, prev_angle_d;
  logic                    prev_vld_q, prev_vld_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SHIFT-1:0]        cnt_q, cnt_d;
  logic signed [15:0]      out_q, out_d;
  logic                    vld_q, vld_d;
  logic                    last_q, last_d;

  logic                    unused_ok;

  // 16-bit modulo subtraction lands directly on the principal value (-pi..+pi).
  function automatic logic signed [15:0] phase_diff(input logic signed [15:0] cur,
                                                    input logic signed [15:0] prev);
    return cur - prev;
  endfunction

  function automatic logic signed [15:0] scale_out(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] sh;
    sh = x >>> SHIFT;
    return sh[15:0];
  endfunction

  assign angle = $signed(s00_axis_tdata[31:16]);
  assign mag   = s00_axis_tdata[15:0];

`ifdef FM_DISCRIM_SQUELCH_EN
  assign squelch = (mag < MAG_THRESH);
`else
  assign squelch = 1'b0;
`endif

  assign unused_ok = &{1'b0, s00_axis_tstrb, s00_axis_tdata, mag, MAG_THRESH};

  assign s00_axis_tready = !s00_axis_areset && (!vld_q || m00_axis_tready);
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign close           = (cnt_q == SHIFT'(DECIM - 1)) || s00_axis_tlast;
  assign diff            = (!prev_vld_q || squelch) ? 16'sd0 : phase_diff(angle, prev_angle_q);
  assign acc_sum         = acc_q + $signed({{SHIFT{diff[15]}}, diff});

  always_comb begin
    prev_angle_d = prev_angle_q;
    prev_vld_d   = prev_vld_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    vld_d        = vld_q;
    last_d       = last_q;
    if (vld_q && m00_axis_tready) begin
      vld_d = 1'b0;
    end
    if (accept) begin
      prev_angle_d = angle;
      prev_vld_d   = 1'b1;
      if (close) begin
        // Output slot is guaranteed free here: accept implies it is empty or draining now.
        acc_d  = '0;
        cnt_d  = '0;
        out_d  = scale_out(acc_sum);
        vld_d  = 1'b1;
        last_d = s00_axis_tlast;
        if (s00_axis_tlast) begin
          prev_vld_d = 1'b0;
        end
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      prev_angle_q <= '0;
      prev_vld_q   <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      vld_q        <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      prev_angle_q <= prev_angle_d;
      prev_vld_q   <= prev_vld_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      vld_q        <= vld_d;
      last_q       <= last_d;
    end
  end

  assign m00_axis_tvalid = vld_q;
  assign m00_axis_tlast  = last_q;
  assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-16){out_q[15]}}, out_q};
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_fm_discrim.sv
// Scoreboard bench for fm_discrim: randomized and directed streams against a window-sum reference model.
module tb_fm_discrim;

  localparam int DECIM = 8;

  logic        clk;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [3:0]  s_tstrb;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  m_tstrb;

  fm_discrim dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tstrb  (s_tstrb),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tstrb  (m_tstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] expq[$];
  int          rmode = 0;
  logic        gap_en = 1'b0;
  logic        done = 1'b0;
  logic        final_done = 1'b0;

  // reference model state: phase history and the current window as a plain integer sum
  int          prev_ang = 0;
  logic        have_prev = 1'b0;
  int          win_sum = 0;
  int          win_n = 0;

  int          rst_cnt = 0;
  logic        stalled = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void model_step(input logic [15:0] ang, input logic quiet, input logic last);
    int a, d, q;
    logic [15:0] o;
    a = int'($signed(ang));
    if (!have_prev || quiet) d = 0;
    else d = ((a - prev_ang + 32768 + 65536) % 65536) - 32768;
    prev_ang  = a;
    have_prev = 1'b1;
    win_sum  += d;
    win_n++;
    if (win_n == DECIM || last) begin
      q = (win_sum - (((win_sum % DECIM) + DECIM) % DECIM)) / DECIM;
      o = q[15:0];
      expq.push_back({last, {16{o[15]}}, o});
      win_sum = 0;
      win_n   = 0;
      if (last) have_prev = 1'b0;
    end
  endfunction

  // monitor: inputs change just after posedge, so negedge sees the values the next edge will act on
  always @(negedge clk) begin
    logic [32:0] e;
    logic        quiet;
    if (rst) begin
      rst_cnt++;
      expq.delete();
      have_prev = 1'b0;
      win_sum   = 0;
      win_n     = 0;
      stalled   = 1'b0;
      check("rst_s_tready", {31'd0, s_tready}, 32'd0);
      if (rst_cnt >= 2) begin
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
      end
    end else begin
      if (rst_cnt != 0) begin
        check("post_rst_s_tready", {31'd0, s_tready}, 32'd1);
        check("post_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      end
      rst_cnt = 0;
      check("tready_rule", {31'd0, s_tready}, {31'd0, (!m_tvalid || m_tready)});
      check("tstrb", {28'd0, m_tstrb}, 32'h0000000F);
      if (stalled) begin
        check("hold_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("hold_tdata", m_tdata, held_data);
        check("hold_tlast", {31'd0, m_tlast}, {31'd0, held_last});
      end
      stalled   = m_tvalid && !m_tready;
      held_data = m_tdata;
      held_last = m_tlast;
      if (m_tvalid && m_tready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got 0x%08h expected none", m_tdata);
        end else begin
          e = expq.pop_front();
          if (m_tdata !== e[31:0] || m_tlast !== e[32]) begin
            failures++;
            $display("FAIL output: got data 0x%08h last %0b expected data 0x%08h last %0b",
                     m_tdata, m_tlast, e[31:0], e[32]);
          end
        end
      end
      if (s_tvalid && s_tready) begin
        quiet = 1'b0;
`ifdef FM_DISCRIM_SQUELCH_EN
        quiet = (s_tdata[15:0] < 16'd64);
`endif
        model_step(s_tdata[31:16], quiet, s_tlast);
      end
      if (done && !final_done) begin
        check("queue_drained", expq.size(), 32'd0);
        final_done = 1'b1;
      end
    end
  end

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 3) != 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [15:0] ang, input logic [15:0] mag, input logic last);
    int   n;
    logic took;
    if (gap_en && $urandom_range(0, 2) == 0) begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = {ang, mag};
    s_tlast  = last;
    s_tstrb  = 4'($urandom);
    n = 0;
    took = 1'b0;
    while (!took && n < 500) begin
      @(negedge clk);
      took = s_tready && !rst;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!took) begin
      $display("FAIL send_timeout: got no acceptance expected acceptance within 500 cycles");
      $fatal(1, "input stalled");
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic ramp(input int n, input logic [15:0] start, input logic [15:0] step, input logic [15:0] mag);
    logic [15:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      send(a, mag, 1'b0);
      a = a + step;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    s_tstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ramp: 0x00E0 first, then 0x0100
    ramp(40, 16'h0000, 16'h0100, 16'h1000);
    // wrap across +/-pi in both directions
    ramp(32, 16'h7F00, 16'h0200, 16'h1000);
    ramp(32, 16'h8100, 16'hFE00, 16'h1000);
    // early close on third sample, then restart with diff 0
    send(16'h0000, 16'h1000, 1'b0);
    send(16'h0100, 16'h1000, 1'b0);
    send(16'h0200, 16'h1000, 1'b1);
    ramp(16, 16'h1000, 16'h0100, 16'h1000);
    // low-magnitude window
    ramp(16, 16'h0000, 16'h0100, 16'h0010);

    // backpressure with continuous input
    fork
      ramp(40, 16'h2000, 16'h0180, 16'h0800);
      begin
        rmode = 2;
        repeat (20) @(posedge clk);
        #1;
        rmode = 0;
      end
    join

    // random traffic with random downstream stalls
    rmode = 1;
    gap_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom), 16'($urandom_range(0, 127)), ($urandom_range(0, 15) == 0));
    end
    gap_en = 1'b0;

    // reset with an output pending
    rmode = 2;
    n = 0;
    while (!m_tvalid && n < 16) begin
      send(16'($urandom), 16'h1000, 1'b0);
      n++;
    end
    do_reset(2);
    // reset mid-window
    rmode = 0;
    ramp(5, 16'h4000, 16'h0300, 16'h1000);
    do_reset(2);
    ramp(24, 16'h0000, 16'h0100, 16'h1000);

    rmode = 0;
    n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
